// File: rtl/switch_node_pkg.sv
// Shared types and route-field helpers for the radix-N butterfly switch node.
// Route helpers work on routes up to 32 bits wide.
package switch_node_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  function automatic int route_lsb(
    input int cw,
    input int d,
    input int stages
  );
    return cw - TYPE_W - d * stages;
  endfunction

  function automatic logic [31:0] route_digit(
    input logic [31:0] route,
    input int          d,
    input int          stages
  );
    logic [31:0] m;
    m = (32'd1 << d) - 32'd1;
    return (route >> (d * (stages - 1))) & m;
  endfunction

  // Move the consumed top digit to the bottom for the next stage.
  function automatic logic [31:0] route_rotate(
    input logic [31:0] route,
    input int          d,
    input int          stages
  );
    int          rw;
    logic [31:0] m;
    rw = d * stages;
    m  = (rw >= 32) ? '1 : ((32'd1 << rw) - 32'd1);
    return ((route << d) | (route >> (rw - d))) & m;
  endfunction

endpackage

// File: rtl/switch_node_radix_fifo.sv
// sn_fifo: synchronous FIFO with registered occupancy count.
// dout shows the head entry while not empty.
module sn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/switch_node_radix.sv
// Radix-N butterfly switch node: input FIFOs, wormhole-locked RR arbiters.
// SWITCH_NODE_RADIX_PERF_EN adds per-output flit/stall counters.
module switch_node_radix
  import switch_node_pkg::*;
#(
  parameter int RADIX         = 4,
  parameter int CHANNEL_WIDTH = 18,
  parameter int STAGES        = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [RADIX-1:0]                      in_valid,
  output logic [RADIX-1:0]                      in_ready,
  input  logic [RADIX-1:0][CHANNEL_WIDTH-1:0]   in_data,
  output logic [RADIX-1:0]                      out_valid,
  input  logic [RADIX-1:0]                      out_ready,
  output logic [RADIX-1:0][CHANNEL_WIDTH-1:0]   out_data
`ifdef SWITCH_NODE_RADIX_PERF_EN
  ,
  output logic [RADIX-1:0][31:0]                perf_flit_cnt,
  output logic [RADIX-1:0][31:0]                perf_stall_cnt
`endif
);

  localparam int CW      = CHANNEL_WIDTH;
  localparam int D       = $clog2(RADIX);
  localparam int ROUTE_W = STAGES * D;
  localparam int RL      = route_lsb(CW, D, STAGES);

  logic [RADIX-1:0]          push;
  logic [RADIX-1:0]          pop;
  logic [RADIX-1:0]          full;
  logic [RADIX-1:0]          empty;
  logic [RADIX-1:0][CW-1:0]  fq;
  logic [RADIX-1:0][CW-1:0]  fmod;
  logic [RADIX-1:0][D-1:0]   digit;
  logic [RADIX-1:0]          hdr;
  logic [RADIX-1:0]          in_locked;
  logic [RADIX-1:0][RADIX-1:0] req;

  logic [RADIX-1:0]          lock_vld;
  logic [RADIX-1:0][D-1:0]   lock_in;
  logic [RADIX-1:0][D-1:0]   rr_ptr;

  logic [RADIX-1:0]          load;
  logic [RADIX-1:0]          xfer;
  logic [RADIX-1:0]          gnt_vld;
  logic [RADIX-1:0][D-1:0]   gnt_idx;
  flit_type_e                gtype [RADIX];

  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  for (genvar i = 0; i < RADIX; i++) begin : g_in
    sn_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .din   (in_data[i]),
      .pop   (pop[i]),
      .dout  (fq[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  always_comb begin
    hdr   = '0;
    digit = '0;
    fmod  = fq;
    for (int i = 0; i < RADIX; i++) begin
      hdr[i] = (flit_type_e'(fq[i][CW-1 -: TYPE_W]) == FT_HEAD) ||
               (flit_type_e'(fq[i][CW-1 -: TYPE_W]) == FT_SINGLE);
      digit[i] = D'(route_digit(32'(fq[i][RL +: ROUTE_W]), D, STAGES));
      if (hdr[i]) begin
        fmod[i][RL +: ROUTE_W] =
          ROUTE_W'(route_rotate(32'(fq[i][RL +: ROUTE_W]), D, STAGES));
      end
    end
  end

  // An input holding a lock may only talk to its locked output.
  always_comb begin
    in_locked = '0;
    req       = '0;
    for (int i = 0; i < RADIX; i++) begin
      for (int o = 0; o < RADIX; o++) begin
        if (lock_vld[o] && lock_in[o] == D'(i)) in_locked[i] = 1'b1;
      end
    end
    for (int o = 0; o < RADIX; o++) begin
      for (int i = 0; i < RADIX; i++) begin
        if (!empty[i]) begin
          if (in_locked[i])
            req[o][i] = lock_vld[o] && (lock_in[o] == D'(i));
          else
            req[o][i] = hdr[i] && (digit[i] == D'(o)) && !lock_vld[o];
        end
      end
    end
  end

  always_comb begin
    logic [D-1:0] idx;
    idx     = '0;
    load    = '0;
    xfer    = '0;
    gnt_vld = '0;
    gnt_idx = '0;
    pop     = '0;
    for (int o = 0; o < RADIX; o++) begin
      load[o] = ~out_valid[o] | out_ready[o];
      for (int k = 0; k < RADIX; k++) begin
        idx = rr_ptr[o] + D'(k);
        if (!gnt_vld[o] && req[o][idx]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = idx;
        end
      end
      xfer[o] = load[o] & gnt_vld[o];
      if (xfer[o]) pop[gnt_idx[o]] = 1'b1;
      gtype[o] = flit_type_e'(fq[gnt_idx[o]][CW-1 -: TYPE_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      lock_vld  <= '0;
      lock_in   <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int o = 0; o < RADIX; o++) begin
        if (load[o]) out_valid[o] <= gnt_vld[o];
        if (xfer[o]) begin
          out_data[o] <= fmod[gnt_idx[o]];
          unique case (gtype[o])
            FT_HEAD: begin
              lock_vld[o] <= 1'b1;
              lock_in[o]  <= gnt_idx[o];
            end
            FT_TAIL, FT_SINGLE: begin
              lock_vld[o] <= 1'b0;
              rr_ptr[o]   <= gnt_idx[o] + D'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef SWITCH_NODE_RADIX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flit_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int o = 0; o < RADIX; o++) begin
        if (out_valid[o] && out_ready[o] && perf_flit_cnt[o] != '1)
          perf_flit_cnt[o] <= perf_flit_cnt[o] + 32'd1;
        if (out_valid[o] && !out_ready[o] && perf_stall_cnt[o] != '1)
          perf_stall_cnt[o] <= perf_stall_cnt[o] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_switch_node_radix.sv
// Directed bench for switch_node_radix (RADIX=4, CW=18, STAGES=3).
// Define SWITCH_NODE_RADIX_PERF_EN to also check the perf counters.
module tb_switch_node_radix;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [3:0][17:0]   in_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [3:0][17:0]   out_data;
`ifdef SWITCH_NODE_RADIX_PERF_EN
  logic [3:0][31:0]   perf_flit_cnt;
  logic [3:0][31:0]   perf_stall_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  switch_node_radix #(
    .RADIX         (4),
    .CHANNEL_WIDTH (18),
    .STAGES        (3),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SWITCH_NODE_RADIX_PERF_EN
    ,
    .perf_flit_cnt  (perf_flit_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [17:0] mk(
    input logic [1:0] t,
    input logic [5:0] r,
    input logic [9:0] p
  );
    return {t, r, p};
  endfunction

  task automatic check(
    input string       tag,
    input logic [71:0] obs,
    input logic [71:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] q [$];
  logic [17:0] p0 [3];
  logic [17:0] p1 [3];
  logic [17:0] e2 [6];
  logic [5:0]  rt [4];
  logic        acc;
  int          k;

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 4'hF;
    #1;
    check("rst_in_ready", 72'(in_ready), 72'(4'hF));
    check("rst_out_valid", 72'(out_valid), 72'(4'h0));
    check("rst_out_data", 72'(out_data), 72'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single flit in0 -> out2 with route rotation
    in_valid   = 4'b0001;
    in_data[0] = mk(2'b11, 6'b100111, 10'h155);
    step();
    in_valid = '0;
    check("t1_edgeN", 72'(out_valid), 72'(4'b0000));
    step();
    check("t1_valid", 72'(out_valid), 72'(4'b0100));
    check("t1_data", 72'(out_data[2]), 72'(mk(2'b11, 6'b011110, 10'h155)));
    step();
    check("t1_drain", 72'(out_valid), 72'(4'b0000));

    // Two packets contend for out3: no interleaving
    p0[0] = mk(2'b01, 6'b110000, 10'h001);
    p0[1] = mk(2'b00, 6'b000000, 10'h002);
    p0[2] = mk(2'b10, 6'b000000, 10'h003);
    p1[0] = mk(2'b01, 6'b110001, 10'h011);
    p1[1] = mk(2'b00, 6'b000000, 10'h012);
    p1[2] = mk(2'b10, 6'b000000, 10'h013);
    e2[0] = mk(2'b01, 6'b000011, 10'h001);
    e2[1] = p0[1];
    e2[2] = p0[2];
    e2[3] = mk(2'b01, 6'b000111, 10'h011);
    e2[4] = p1[1];
    e2[5] = p1[2];
    q.delete();
    for (int c = 0; c < 12; c++) begin
      if (out_valid[3] && out_ready[3]) q.push_back(out_data[3]);
      if (c < 3) begin
        in_valid   = 4'b0011;
        in_data[0] = p0[c];
        in_data[1] = p1[c];
      end else begin
        in_valid = '0;
      end
      step();
    end
    check("t2_count", 72'(q.size()), 72'd6);
    for (int j = 0; j < 6; j++)
      check($sformatf("t2_flit%0d", j),
            72'((j < q.size()) ? q[j] : 18'h3FFFF), 72'(e2[j]));

    // rr_ptr[3] now 2: in2 beats in0
    q.delete();
    for (int c = 0; c < 6; c++) begin
      if (out_valid[3] && out_ready[3]) q.push_back(out_data[3]);
      if (c == 0) begin
        in_valid   = 4'b0101;
        in_data[0] = mk(2'b11, 6'b110000, 10'h021);
        in_data[2] = mk(2'b11, 6'b110000, 10'h022);
      end else begin
        in_valid = '0;
      end
      step();
    end
    check("t2b_count", 72'(q.size()), 72'd2);
    check("t2b_first", 72'((q.size() > 0) ? q[0] : 18'h3FFFF),
          72'(mk(2'b11, 6'b000011, 10'h022)));
    check("t2b_second", 72'((q.size() > 1) ? q[1] : 18'h3FFFF),
          72'(mk(2'b11, 6'b000011, 10'h021)));

    // Backpressure on out1
    out_ready = 4'b1101;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = (k < 8);
      in_data[0]  = mk(2'b11, 6'b010000, 10'(256 + k));
      acc = in_valid[0] & in_ready[0];
      step();
      if (acc) k++;
    end
    check("t3_accepted", 72'(k), 72'd5);
    check("t3_in_ready", 72'(in_ready[0]), 72'd0);
    out_ready = 4'hF;
    q.delete();
    for (int c = 0; c < 20; c++) begin
      if (out_valid[1] && out_ready[1]) q.push_back(out_data[1]);
      in_valid[0] = (k < 8);
      in_data[0]  = mk(2'b11, 6'b010000, 10'(256 + k));
      acc = in_valid[0] & in_ready[0];
      step();
      if (acc) k++;
    end
    in_valid = '0;
    check("t3_total", 72'(k), 72'd8);
    check("t3_count", 72'(q.size()), 72'd8);
    for (int j = 0; j < 8; j++)
      check($sformatf("t3_flit%0d", j),
            72'((j < q.size()) ? q[j] : 18'h3FFFF),
            72'(mk(2'b11, 6'b000001, 10'(256 + j))));

    // Four inputs to four distinct outputs
    rt[0] = 6'b010000;
    rt[1] = 6'b100000;
    rt[2] = 6'b110000;
    rt[3] = 6'b000000;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        in_valid = 4'hF;
        for (int i = 0; i < 4; i++)
          in_data[i] = mk(2'b11, rt[i], 10'(512 + 16 * i + c));
      end else begin
        in_valid = '0;
      end
      step();
      if (c == 0) check("t4_edgeN", 72'(out_valid), 72'(4'h0));
      if (c >= 1 && c <= 3)
        check($sformatf("t4_all%0d", c), 72'(out_valid), 72'(4'hF));
      if (c == 4) check("t4_drain", 72'(out_valid), 72'(4'h0));
      if (c == 1)
        check("t4_out0", 72'(out_data[0]),
              72'(mk(2'b11, 6'b000000, 10'(512 + 48))));
      if (c == 3)
        check("t4_out2", 72'(out_data[2]),
              72'(mk(2'b11, 6'b000010, 10'(512 + 16 + 2))));
    end

    // Reset in the middle of a packet
    out_ready   = 4'b1011;
    in_valid    = 4'b0001;
    in_data[0]  = mk(2'b01, 6'b100000, 10'h3A0);
    step();
    in_data[0]  = mk(2'b00, 6'b000000, 10'h3A1);
    step();
    in_valid = '0;
    step();
    step();
    check("t5_pre_valid", 72'(out_valid), 72'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 72'(out_valid), 72'(4'h0));
    check("t5_rst_ready", 72'(in_ready), 72'(4'hF));
    step();
    rst_n      = 1'b1;
    out_ready  = 4'hF;
    in_valid   = 4'b0010;
    in_data[1] = mk(2'b11, 6'b100000, 10'h3B0);
    step();
    in_valid = '0;
    step();
    check("t5_new_valid", 72'(out_valid), 72'(4'b0100));
    check("t5_new_data", 72'(out_data[2]),
          72'(mk(2'b11, 6'b000010, 10'h3B0)));
    step();
    check("t5_no_stale", 72'(out_valid), 72'(4'h0));

`ifdef SWITCH_NODE_RADIX_PERF_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("perf_rst", 72'(perf_flit_cnt[0]), 72'd0);
    out_ready = 4'b1110;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid[3] = (k < 5);
      in_data[3]  = mk(2'b11, 6'b000000, 10'(k));
      acc = in_valid[3] & in_ready[3];
      step();
      if (acc) k++;
    end
    in_valid  = '0;
    out_ready = 4'hF;
    repeat (8) step();
    check("perf_accepted", 72'(k), 72'd5);
    check("perf_flits", 72'(perf_flit_cnt[0]), 72'd5);
    check("perf_stalls", 72'(perf_stall_cnt[0]), 72'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
